flash_therm_encoder: RTL and testbench



---
 rtl/flash_therm_encoder_pkg.sv | 25 ++
 rtl/flash_therm_encoder_if.sv | 34 +++
 rtl/flash_therm_encoder_therm_bubble_fix.sv | 28 ++
 rtl/flash_therm_encoder.sv | 178 +++++++++++++++++
 tb/tb_flash_therm_encoder.sv | 308 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/flash_therm_encoder_pkg.sv
// Shared flash-ADC helpers: comparator-count derivation, 3-input majority, ones-count.
// Pure functions only, no state; popcount is sized for the widest legal comparator bank.
package flash_therm_encoder_pkg;

    localparam int MAX_NCOMP = 63;
    localparam int CNT_W     = 7;

    function automatic int ncomp_f(input int nbits);
        return (1 << nbits) - 1;
    endfunction

    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

    function automatic logic [CNT_W-1:0] popcount(input logic [MAX_NCOMP-1:0] v);
        logic [CNT_W-1:0] n;
        n = '0;
        for (int i = 0; i < MAX_NCOMP; i++) begin
            n = n + {{(CNT_W-1){1'b0}}, v[i]};
        end
        return n;
    endfunction

endpackage

// File: rtl/flash_therm_encoder_if.sv
// Comparator-in / code-out bundle of the flash encoder; slave = encoder, master = its environment.
// Per-sample outputs are pulse-qualified; only the averaged result uses valid/ready.
interface flash_therm_encoder_if #(
    parameter int NBITS = 4,
    parameter int ERR_W = 8
);
    import flash_therm_encoder_pkg::*;

    localparam int NCOMP = ncomp_f(NBITS);

    logic [NCOMP-1:0] therm;
    logic             in_valid;
    logic             mode_avg;
    logic             err_clr;
    logic             code_valid;
    logic [NBITS-1:0] code;
    logic             bubble;
    logic             avg_valid;
    logic             avg_ready;
    logic [NBITS-1:0] avg_code;
    logic [ERR_W-1:0] err_cnt;
    logic             ovf;

    modport slave (
        input  therm, in_valid, mode_avg, err_clr, avg_ready,
        output code_valid, code, bubble, avg_valid, avg_code, err_cnt, ovf
    );

    modport master (
        output therm, in_valid, mode_avg, err_clr, avg_ready,
        input  code_valid, code, bubble, avg_valid, avg_code, err_cnt, ovf
    );

endinterface

// File: rtl/flash_therm_encoder_therm_bubble_fix.sv
// Majority bubble correction of a thermometer vector plus the bubble flag; purely combinational.
// Bits outside the bank read as 1 below bit 0 and 0 above the top comparator.
module therm_bubble_fix
    import flash_therm_encoder_pkg::*;
#(
    parameter int NCOMP = 15
) (
    input  logic [NCOMP-1:0] i_therm,
    output logic [NCOMP-1:0] o_corr,
    output logic             o_bubble
);

    logic [NCOMP+1:0] w_ext;
    logic [NCOMP-1:0] w_corr;
    logic [NCOMP-1:0] w_corr_inc;

    assign w_ext = {1'b0, i_therm, 1'b1};

    for (genvar i = 0; i < NCOMP; i++) begin : g_maj
        assign w_corr[i] = maj3(w_ext[i], w_ext[i+1], w_ext[i+2]);
    end

    // A clean 0..01..1 pattern has no bit in common with itself plus one.
    assign w_corr_inc = w_corr + 1'b1;
    assign o_bubble   = (w_corr != i_therm) || ((w_corr & w_corr_inc) != '0);
    assign o_corr     = w_corr;

endmodule

// File: rtl/flash_therm_encoder.sv
// Pipelined thermometer-to-binary encoder with optional block averaging; code_valid SYNC_STAGES+2 after therm.
// Per-sample path never stalls; the averaged result is held until accepted, later blocks drop and set ovf.
module flash_therm_encoder
    import flash_therm_encoder_pkg::*;
#(
    parameter int NBITS       = 4,
    parameter int SYNC_STAGES = 2,
    parameter int AVG_LOG2    = 2,
    parameter int ERR_W       = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    flash_therm_encoder_if.slave  bus
);

    localparam int NCOMP = ncomp_f(NBITS);
    localparam int ACC_W = NBITS + AVG_LOG2;
    localparam int RND_W = ACC_W + 1;
    localparam logic [RND_W-1:0] RND_HALF  = RND_W'(2 ** (AVG_LOG2 - 1));
    localparam logic [NBITS:0]   NCOMP_W1  = (NBITS + 1)'(NCOMP);
    localparam logic [NBITS-1:0] NCOMP_MAX = NBITS'(NCOMP);

    logic [NCOMP-1:0]     r_sync_therm [SYNC_STAGES];
    logic [SYNC_STAGES-1:0] r_sync_vld;

    logic [NCOMP-1:0]     w_corr;
    logic                 w_bubble;
    logic [NCOMP-1:0]     r_corr;
    logic                 r_corr_vld;
    logic                 r_corr_bub;

    logic [MAX_NCOMP-1:0] w_corr_ext;
    logic [NBITS-1:0]     w_code;
    logic [NBITS-1:0]     r_code;
    logic                 r_code_vld;
    logic                 r_bub;

    logic [ERR_W-1:0]     r_err;
    logic                 r_ovf;

    logic [ACC_W-1:0]     r_acc;
    logic [AVG_LOG2-1:0]  r_cnt;
    logic                 r_mode_q;
    logic                 r_avg_vld;
    logic [NBITS-1:0]     r_avg_code;

    logic [ACC_W-1:0]     w_sum;
    logic [RND_W-1:0]     w_rnd;
    logic [NBITS:0]       w_shift;
    logic [NBITS-1:0]     w_avg;
    logic                 w_mode_chg;
    logic                 w_blk_done;
    logic                 w_can_load;

    // Metastability chain: therm is asynchronous, so it shifts every cycle alongside its qualifier.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                r_sync_therm[i] <= '0;
            end
            r_sync_vld <= '0;
        end else begin
            r_sync_therm[0] <= bus.therm;
            r_sync_vld[0]   <= bus.in_valid;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                r_sync_therm[i] <= r_sync_therm[i-1];
                r_sync_vld[i]   <= r_sync_vld[i-1];
            end
        end
    end

    therm_bubble_fix #(
        .NCOMP (NCOMP)
    ) u_fix (
        .i_therm  (r_sync_therm[SYNC_STAGES-1]),
        .o_corr   (w_corr),
        .o_bubble (w_bubble)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_corr     <= '0;
            r_corr_vld <= 1'b0;
            r_corr_bub <= 1'b0;
        end else begin
            r_corr     <= w_corr;
            r_corr_vld <= r_sync_vld[SYNC_STAGES-1];
            r_corr_bub <= w_bubble;
        end
    end

    // Ones-count tolerates any residual non-monotonic pattern after correction.
    assign w_corr_ext = MAX_NCOMP'(r_corr);
    assign w_code     = NBITS'(popcount(w_corr_ext));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_code     <= '0;
            r_code_vld <= 1'b0;
            r_bub      <= 1'b0;
        end else begin
            r_code     <= w_code;
            r_code_vld <= r_corr_vld;
            r_bub      <= r_corr_vld & r_corr_bub;
        end
    end

    // Counted on the same edge the sample's code_valid appears; a clear always wins.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_err <= '0;
        end else if (bus.err_clr) begin
            r_err <= '0;
        end else if (r_corr_vld && r_corr_bub && (r_err != '1)) begin
            r_err <= r_err + 1'b1;
        end
    end

    assign w_sum      = r_acc + ACC_W'(r_code);
    assign w_rnd      = RND_W'(w_sum) + RND_HALF;
    assign w_shift    = w_rnd[RND_W-1:AVG_LOG2];
    assign w_avg      = (w_shift > NCOMP_W1) ? NCOMP_MAX : w_shift[NBITS-1:0];
    assign w_mode_chg = bus.mode_avg != r_mode_q;
    assign w_blk_done = r_code_vld && bus.mode_avg && !w_mode_chg && (r_cnt == '1);
    assign w_can_load = !r_avg_vld || bus.avg_ready;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_mode_q <= 1'b0;
            r_acc    <= '0;
            r_cnt    <= '0;
        end else begin
            r_mode_q <= bus.mode_avg;
            if (w_mode_chg) begin
                r_acc <= '0;
                r_cnt <= '0;
            end else if (r_code_vld && bus.mode_avg) begin
                if (r_cnt == '1) begin
                    r_acc <= '0;
                    r_cnt <= '0;
                end else begin
                    r_acc <= w_sum;
                    r_cnt <= r_cnt + 1'b1;
                end
            end
        end
    end

    // avg_code only moves on a load, and a load needs the holding register empty or draining.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_avg_vld  <= 1'b0;
            r_avg_code <= '0;
            r_ovf      <= 1'b0;
        end else begin
            if (w_blk_done && w_can_load) begin
                r_avg_vld  <= 1'b1;
                r_avg_code <= w_avg;
            end else if (r_avg_vld && bus.avg_ready) begin
                r_avg_vld  <= 1'b0;
            end
            if (bus.err_clr) begin
                r_ovf <= 1'b0;
            end else if (w_blk_done && !w_can_load) begin
                r_ovf <= 1'b1;
            end
        end
    end

    assign bus.code_valid = r_code_vld;
    assign bus.code       = r_code;
    assign bus.bubble     = r_bub;
    assign bus.avg_valid  = r_avg_vld;
    assign bus.avg_code   = r_avg_code;
    assign bus.err_cnt    = r_err;
    assign bus.ovf        = r_ovf;

endmodule

// File: tb/tb_flash_therm_encoder.sv
// Directed bench for flash_therm_encoder: per-sample and averaged results are scoreboarded,
// expected values come from an independent thermometer model.
module tb_flash_therm_encoder;

    localparam int NBITS = 4;
    localparam int SYNC  = 2;
    localparam int AVGL  = 2;
    localparam int ERR_W = 8;
    localparam int NCOMP = 15;
    localparam int LAT   = SYNC + 2;

    typedef struct {
        logic [3:0] code;
        logic       bub;
        int         cyc;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   cyc = 0;
    int   n_vec = 0;
    int   n_err = 0;
    int   exp_err = 0;
    int   p = 0;
    exp_t sbq[$];
    logic [3:0] avgq[$];
    logic       hold_prev = 1'b0;
    logic [3:0] prev_avg = '0;
    logic [14:0] bub_vec;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    flash_therm_encoder_if #(.NBITS(NBITS), .ERR_W(ERR_W)) bus ();

    flash_therm_encoder #(
        .NBITS       (NBITS),
        .SYNC_STAGES (SYNC),
        .AVG_LOG2    (AVGL),
        .ERR_W       (ERR_W)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_vec++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    function automatic logic [14:0] th(input int k);
        logic [15:0] v;
        v = (16'd1 << k) - 16'd1;
        return v[14:0];
    endfunction

    function automatic int exp_avg(input int a, input int b, input int c, input int d);
        int r;
        r = (a + b + c + d + (1 << (AVGL - 1))) >> AVGL;
        return (r > NCOMP) ? NCOMP : r;
    endfunction

    function automatic void model(input logic [14:0] t, output logic [3:0] code, output logic bub);
        logic [16:0] te;
        logic [14:0] c;
        int          ones;
        int          s;
        bit          seen0;
        bit          nonmono;
        te = {1'b0, t, 1'b1};
        ones = 0;
        seen0 = 0;
        nonmono = 0;
        for (int i = 0; i < NCOMP; i++) begin
            s = int'(te[i]) + int'(te[i+1]) + int'(te[i+2]);
            c[i] = (s >= 2);
            if (c[i]) ones++;
        end
        for (int i = 0; i < NCOMP; i++) begin
            if (!c[i]) seen0 = 1;
            else if (seen0) nonmono = 1;
        end
        code = 4'(ones);
        bub = (c != t) || nonmono;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic to_neg(input int target);
        do @(negedge clk); while (cyc < target);
    endtask

    task automatic drain();
        to_neg(cyc + LAT + 2);
        tick();
    endtask

    task automatic send(input logic [14:0] t, input bit track);
        exp_t e;
        logic [3:0] c;
        logic b;
        model(t, c, b);
        if (track) begin
            e.code = c;
            e.bub  = b;
            e.cyc  = cyc + LAT;
            sbq.push_back(e);
            if (b && exp_err < 255) exp_err++;
        end
        bus.therm    = t;
        bus.in_valid = 1'b1;
        tick();
        bus.in_valid = 1'b0;
    endtask

    task automatic check_reset_vals();
        check("rst_code_valid", bus.code_valid, 0);
        check("rst_code",       bus.code, 0);
        check("rst_bubble",     bus.bubble, 0);
        check("rst_avg_code",   bus.avg_code, 0);
        check("rst_avg_valid",  bus.avg_valid, 0);
        check("rst_err_cnt",    bus.err_cnt, 0);
        check("rst_ovf",        bus.ovf, 0);
    endtask

    always @(negedge clk) begin : monitor
        exp_t e;
        if (bus.code_valid) begin
            if (sbq.size() == 0) begin
                check("unexpected_code_valid", bus.code_valid, 0);
            end else begin
                e = sbq.pop_front();
                check("code", bus.code, e.code);
                check("bubble", bus.bubble, e.bub);
                check("latency", cyc, e.cyc);
            end
        end
        if (bus.avg_valid && bus.avg_ready) begin
            if (avgq.size() == 0) check("unexpected_avg", bus.avg_valid, 0);
            else check("avg_code", bus.avg_code, avgq.pop_front());
        end
        if (hold_prev && rst_n && bus.avg_valid) check("avg_hold", bus.avg_code, prev_avg);
        hold_prev = bus.avg_valid && !bus.avg_ready;
        prev_avg  = bus.avg_code;
    end

    initial begin
        bus.therm = '0;
        bus.in_valid = 1'b0;
        bus.mode_avg = 1'b0;
        bus.err_clr = 1'b0;
        bus.avg_ready = 1'b1;
        bub_vec = 15'b000000001011111;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_vals();
        tick();
        rst_n = 1'b1;
        tick();

        // All 16 clean thermometer codes, per-sample mode
        for (int k = 0; k <= NCOMP; k++) send(th(k), 1);
        drain();
        check("sweep_err_cnt", bus.err_cnt, exp_err);
        check("sweep_drained", sbq.size(), 0);
        check("avg_idle_mode0", bus.avg_valid, 0);

        // Hole at bit 5
        send(bub_vec, 1);
        drain();
        check("hole_err_cnt", bus.err_cnt, exp_err);

        // Averaging: 3,4,4,5 then 1,1,1,2 with output timing
        bus.mode_avg = 1'b1;
        tick();
        tick();
        send(th(3), 1);
        send(th(4), 1);
        send(th(4), 1);
        p = cyc;
        send(th(5), 1);
        avgq.push_back(4'(exp_avg(3, 4, 4, 5)));
        to_neg(p + LAT);
        check("avg_early", bus.avg_valid, 0);
        to_neg(p + LAT + 1);
        check("avg_rise", bus.avg_valid, 1);
        to_neg(p + LAT + 2);
        check("avg_fall", bus.avg_valid, 0);
        tick();
        send(th(1), 1);
        send(th(1), 1);
        send(th(1), 1);
        send(th(2), 1);
        avgq.push_back(4'(exp_avg(1, 1, 1, 2)));
        drain();
        check("avg_q_empty1", avgq.size(), 0);

        // Two blocks with no acceptance: first held, second dropped
        bus.avg_ready = 1'b0;
        for (int k = 0; k < 4; k++) send(th(2), 1);
        avgq.push_back(4'(exp_avg(2, 2, 2, 2)));
        for (int k = 0; k < 4; k++) send(th(6), 1);
        drain();
        check("ovf_set", bus.ovf, 1);
        check("held_valid", bus.avg_valid, 1);
        check("held_code", bus.avg_code, exp_avg(2, 2, 2, 2));
        bus.avg_ready = 1'b1;
        tick();
        tick();
        @(negedge clk);
        check("accepted_valid_low", bus.avg_valid, 0);
        check("avg_q_empty2", avgq.size(), 0);
        tick();
        bus.err_clr = 1'b1;
        tick();
        bus.err_clr = 1'b0;
        exp_err = 0;
        @(negedge clk);
        check("ovf_cleared", bus.ovf, 0);
        check("err_cleared", bus.err_cnt, exp_err);
        tick();

        // Mode toggle discards a partial block
        send(th(15), 1);
        send(th(15), 1);
        drain();
        bus.mode_avg = 1'b0;
        tick();
        bus.mode_avg = 1'b1;
        tick();
        send(th(0), 1);
        send(th(0), 1);
        send(th(0), 1);
        send(th(4), 1);
        avgq.push_back(4'(exp_avg(0, 0, 0, 4)));
        drain();
        check("avg_q_empty3", avgq.size(), 0);

        // Saturating bubble counter
        bus.mode_avg = 1'b0;
        tick();
        for (int k = 0; k < 300; k++) send(bub_vec, 1);
        drain();
        check("err_saturated", bus.err_cnt, exp_err);
        check("err_sat_value", bus.err_cnt, 255);
        bus.err_clr = 1'b1;
        tick();
        bus.err_clr = 1'b0;
        exp_err = 0;
        @(negedge clk);
        check("err_clr_after_sat", bus.err_cnt, 0);
        tick();

        // Clear coinciding with a bubble sample reaching the counter
        send(bub_vec, 1);
        tick();
        tick();
        bus.err_clr = 1'b1;
        tick();
        bus.err_clr = 1'b0;
        exp_err = 0;
        drain();
        check("clr_wins", bus.err_cnt, exp_err);
        send(bub_vec, 1);
        drain();
        check("count_resumes", bus.err_cnt, exp_err);

        // Reset with a 2-sample partial average and 3 samples in flight
        bus.mode_avg = 1'b1;
        tick();
        tick();
        send(th(7), 1);
        send(th(7), 1);
        drain();
        send(th(9), 0);
        send(th(9), 0);
        send(th(9), 0);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        exp_err = 0;
        @(negedge clk);
        check_reset_vals();
        tick();
        send(th(8), 1);
        send(th(8), 1);
        send(th(9), 1);
        send(th(9), 1);
        avgq.push_back(4'(exp_avg(8, 8, 9, 9)));
        drain();
        tick();
        tick();
        check("final_sb_empty", sbq.size(), 0);
        check("final_avg_empty", avgq.size(), 0);
        check("final_err_cnt", bus.err_cnt, exp_err);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
